// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh generator: requests a slot every REF_PERIOD clocks, then issues PRE/AREF.
// Define SDRAM_AREF_PRE_EN to precede each AREF with a precharge-all and tRP wait.
module sdram_aref #(
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 7
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        flag_init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        flag_aref_end,
  output logic [3:0]  aref_cmd,
  output logic [12:0] aref_addr,
  output logic        req_miss
);

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [3:0]  CMD_PRE  = 4'b0010;
  localparam logic [3:0]  CMD_AREF = 4'b0001;
  localparam logic [15:0] CNT_LAST = 16'(REF_PERIOD - 1);
  // Last delay-counter value of each wait state (wait lasts T-1 cycles)
  localparam logic [3:0]  RP_LAST  = 4'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [3:0]  RFC_LAST = 4'((T_RFC > 1) ? T_RFC - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  dly_q, dly_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        req_q, req_d;
  logic        miss_q, miss_d;
  logic        end_q, end_d;
  logic        tick;
  logic        accept;

  assign tick   = flag_init_end && (cnt_q == CNT_LAST);
  assign accept = (state_q == S_IDLE) && req_q && aref_en && flag_init_end;

  // A tick on the acceptance edge raises a fresh request rather than a miss
  always_comb begin
    cnt_d  = 16'd0;
    if (flag_init_end && !tick) cnt_d = cnt_q + 16'd1;
    req_d  = tick | (req_q & ~accept);
    miss_d = miss_q | (tick & req_q & ~accept);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef SDRAM_AREF_PRE_EN
          state_d = S_PRE;
`else
          state_d = S_AREF;
`endif
        end
      end
      S_PRE:      state_d = (T_RP > 1) ? S_WAIT_RP : S_AREF;
      S_WAIT_RP:  if (dly_q == RP_LAST) state_d = S_AREF;
      S_AREF:     state_d = (T_RFC > 1) ? S_WAIT_RFC : S_DONE;
      S_WAIT_RFC: if (dly_q == RFC_LAST) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    dly_d = (state_d != state_q) ? 4'd0 : dly_q + 4'd1;

    // Outputs are registered from the next state so they align with it
    cmd_d = CMD_NOP;
    if (state_d == S_PRE)       cmd_d = CMD_PRE;
    else if (state_d == S_AREF) cmd_d = CMD_AREF;
    end_d = (state_d == S_DONE);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      dly_q   <= 4'd0;
      cmd_q   <= CMD_NOP;
      req_q   <= 1'b0;
      miss_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
      miss_q  <= miss_d;
      end_q   <= end_d;
    end
  end

  assign aref_req      = req_q;
  assign req_miss      = miss_q;
  assign flag_aref_end = end_q;
  assign aref_cmd      = cmd_q;
  assign aref_addr     = 13'b0_0100_0000_0000;

endmodule

// File: tb/tb_sdram_aref.sv
// Randomized bench for sdram_aref against an edge-counting reference model.
module tb_sdram_aref;
  localparam int P    = 780;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
`ifdef SDRAM_AREF_PRE_EN
  localparam int PRE_AT  = 0;
  localparam int AREF_AT = TRP;
`else
  localparam int PRE_AT  = -1;
  localparam int AREF_AT = 0;
`endif
  localparam int END_AT = AREF_AT + TRFC;

  logic        sclk;
  logic        s_rst_n;
  logic        flag_init_end;
  logic        aref_en;
  logic        aref_req;
  logic        flag_aref_end;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic        req_miss;

  int checks;
  int errors;

  sdram_aref #(.REF_PERIOD(P), .T_RP(TRP), .T_RFC(TRFC)) dut (
    .sclk          (sclk),
    .s_rst_n       (s_rst_n),
    .flag_init_end (flag_init_end),
    .aref_en       (aref_en),
    .aref_req      (aref_req),
    .flag_aref_end (flag_aref_end),
    .aref_cmd      (aref_cmd),
    .aref_addr     (aref_addr),
    .req_miss      (req_miss)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Reference model: counts edges since reset, tracks the outstanding
  // request and the edge E at which the current sequence was accepted.
  int n;
  int init_edges;
  int seq_e;
  bit seq_active;
  bit m_req;
  bit m_miss;
  bit m_idle;
  bit m_acc;
  bit m_tick;

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      n = 0; init_edges = 0; seq_e = 0;
      seq_active = 0; m_req = 0; m_miss = 0;
    end else begin
      n++;
      m_idle = !seq_active || (n - seq_e >= END_AT + 2);
      m_acc  = m_idle && m_req && aref_en && flag_init_end;
      m_tick = 0;
      if (flag_init_end) begin
        init_edges++;
        m_tick = (init_edges % P) == 0;
      end
      if (m_acc) begin
        seq_active = 1;
        seq_e = n;
      end
      if (m_tick && m_req && !m_acc) m_miss = 1;
      m_req = m_tick || (m_req && !m_acc);
    end
  end

  function automatic logic [3:0] exp_cmd();
    int c;
    if (!seq_active) return 4'b0111;
    c = n - seq_e;
    if (c == PRE_AT)  return 4'b0010;
    if (c == AREF_AT) return 4'b0001;
    return 4'b0111;
  endfunction

  function automatic logic exp_end();
    return seq_active && ((n - seq_e) == END_AT);
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: compare outputs at the falling edge, then drive inputs
  task automatic cyc(input logic en, input logic init);
    @(negedge sclk);
    check("cmd", aref_cmd, exp_cmd());
    check("req", aref_req, m_req);
    check("end", flag_aref_end, exp_end());
    check("miss", req_miss, m_miss);
    check("addr", aref_addr, 13'h0400);
    aref_en       = en;
    flag_init_end = init;
  endtask

  int  rise;
  bit  found;

  initial begin
    checks = 0; errors = 0;
    s_rst_n = 1'b0; flag_init_end = 1'b0; aref_en = 1'b0;
    repeat (3) @(negedge sclk);
    check("rst_cmd", aref_cmd, 4'b0111);
    check("rst_req", aref_req, 0);
    #2 s_rst_n = 1'b1;

    // Waiting for initialisation: grants are ignored
    for (int i = 0; i < 2000; i++) cyc(1'($urandom_range(0, 1)), 1'b0);

    cyc(1'b0, 1'b1);
    rise = -1;
    for (int j = 1; j <= 800; j++) begin
      cyc(1'b0, 1'b1);
      if (aref_req && rise < 0) rise = j;
    end
    check("first_req_edges", rise, 780);

    for (int i = 0; i < 2000; i++) cyc(1'b1, 1'b1);
    for (int i = 0; i < 1600; i++) cyc(1'b0, 1'b1);
    check("miss_set", req_miss, 1);
    for (int i = 0; i < 3000; i++) cyc(1'($urandom_range(0, 3) != 0), 1'b1);
    check("miss_sticky", req_miss, 1);

    // Asynchronous reset landing in the AREF cycle
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cyc(1'b1, 1'b1);
      if (exp_cmd() == 4'b0001) found = 1;
    end
    check("aref_seen", found, 1);
    #1 s_rst_n = 1'b0;
    #1;
    check("arst_cmd", aref_cmd, 4'b0111);
    check("arst_req", aref_req, 0);
    check("arst_end", flag_aref_end, 0);
    check("arst_miss", req_miss, 0);
    @(negedge sclk);
    aref_en = 1'b0; flag_init_end = 1'b1;
    #2 s_rst_n = 1'b1;
    rise = -1;
    for (int j = 1; j <= 800; j++) begin
      cyc(1'b0, 1'b1);
      if (aref_req && rise < 0) rise = j;
    end
    check("req_after_rst", rise, 780);

    for (int i = 0; i < 1000; i++) cyc(1'($urandom_range(0, 1)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
